apb_node_bridge: RTL and testbench

- Parametrised, registered APB 1-to-N node; successor to the fixed-count peripheral bus wrapper.
- Decodes one upstream APB slave port onto NB_SLV downstream APB master ports using runtime start/end address pairs.
- Completes unmapped accesses locally with PSLVERR.
- Adds a register stage between upstream and downstream for timing closure between the SoC interconnect and peripherals.

---
 rtl/apb_node_bridge.sv | 245 ++++++++++++++++++++++++
 tb/tb_apb_node_bridge.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_node_bridge.sv
// ---------------------------------------------------------------------------
// apb_node_bridge
//
// Registered APB 1-to-N node. One upstream APB slave port is decoded onto
// NB_SLV downstream APB master ports using runtime inclusive start/end
// address pairs (lowest index wins on overlap). Accesses that hit no region
// complete locally with PSLVERR. A full register stage sits between the
// upstream and downstream sides, so every transfer is re-launched
// downstream from registered address/data/control.
//
// Optional feature (macro APB_NODE_TIMEOUT_EN):
//   An ACCESS phase that sees no PREADY from the selected peripheral for
//   TIMEOUT_CYCLES cycles is abandoned and answered upstream with PSLVERR,
//   pulsing err_timeout_o. Without the macro ACCESS waits indefinitely and
//   err_timeout_o stays 0.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   s_*                     upstream APB slave port
//   m_paddr_o/pwdata_o/     shared downstream address, data, direction,
//   m_pwrite_o/penable_o    enable (driven from registers)
//   m_psel_o                one-hot downstream select
//   m_prdata_i/pready_i/    per-port downstream responses (packed,
//   m_pslverr_i             port i at bits [i*W +: W])
//   start_addr_i/end_addr_i per-port inclusive region bounds (packed)
//   err_unmapped_o          one-cycle pulse per unmapped access
//   err_timeout_o           one-cycle pulse per timed-out access
// ---------------------------------------------------------------------------
module apb_node_bridge #(
    parameter int NB_SLV         = 12,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [APB_ADDR_WIDTH-1:0]        s_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]        s_pwdata_i,
    input  logic                             s_pwrite_i,
    input  logic                             s_psel_i,
    input  logic                             s_penable_i,
    output logic [APB_DATA_WIDTH-1:0]        s_prdata_o,
    output logic                             s_pready_o,
    output logic                             s_pslverr_o,
    output logic [APB_ADDR_WIDTH-1:0]        m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]        m_pwdata_o,
    output logic                             m_pwrite_o,
    output logic                             m_penable_o,
    output logic [NB_SLV-1:0]                m_psel_o,
    input  logic [NB_SLV*APB_DATA_WIDTH-1:0] m_prdata_i,
    input  logic [NB_SLV-1:0]                m_pready_i,
    input  logic [NB_SLV-1:0]                m_pslverr_i,
    input  logic [NB_SLV*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLV*APB_ADDR_WIDTH-1:0] end_addr_i,
    output logic                             err_unmapped_o,
    output logic                             err_timeout_o
);

    localparam int IDX_W = (NB_SLV > 1) ? $clog2(NB_SLV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP,
        ERR
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic                      write_q;
    logic [IDX_W-1:0]          idx_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      slverr_q;
    logic                      timeout_q;

    logic [IDX_W-1:0]          hit_idx;
    logic                      hit_any;
    logic                      capture;
    logic                      sel_ready;
    logic                      sel_err;
    logic [APB_DATA_WIDTH-1:0] sel_rdata;
    logic                      timeout_hit;

    // Upstream SETUP phase seen while idle: latch the whole request.
    assign capture = (state == IDLE) && s_psel_i && !s_penable_i;

    // -----------------------------------------------------------------------
    // Address decode. Scanning from the top index down lets the lowest
    // matching index overwrite any higher one, so overlaps resolve to it.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no
        // path can leave it unassigned and infer a latch.
        hit_idx = '0;
        hit_any = 1'b0;
        for (int i = NB_SLV - 1; i >= 0; i--) begin
            if ((start_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] <= s_paddr_i) &&
                (s_paddr_i <= end_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
                hit_idx = IDX_W'(i);
                hit_any = 1'b1;
            end
        end
    end

    // Only the captured port's response is looked at; others are ignored.
    assign sel_ready = m_pready_i[idx_q];
    assign sel_err   = m_pslverr_i[idx_q];
    assign sel_rdata = m_prdata_i[idx_q*APB_DATA_WIDTH +: APB_DATA_WIDTH];

`ifdef APB_NODE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state == SETUP) begin
            cnt_q <= '0;
        end else if (state == ACCESS) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q counts completed ACCESS cycles, so the last allowed cycle is the
    // one where it still reads TIMEOUT_CYCLES-1.
    assign timeout_hit = (state == ACCESS) && !sel_ready &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of block ordering.
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nxt = hit_any ? SETUP : ERR;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                // A master that dropped PSEL mid-transfer gets no response.
                if (sel_ready || timeout_hit) begin
                    state_nxt = s_psel_i ? RESP : IDLE;
                end
            end
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Request and response registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (capture) begin
                addr_q  <= s_paddr_i;
                wdata_q <= s_pwdata_i;
                write_q <= s_pwrite_i;
                idx_q   <= hit_idx;
            end
            if (state == ACCESS) begin
                if (timeout_hit) begin
                    rdata_q   <= '0;
                    slverr_q  <= 1'b1;
                    timeout_q <= 1'b1;
                end else if (sel_ready) begin
                    rdata_q   <= write_q ? '0 : sel_rdata;
                    slverr_q  <= sel_err;
                    timeout_q <= 1'b0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM outputs (decoded from state so reset clears them immediately)
    // -----------------------------------------------------------------------
    always_comb begin
        m_psel_o       = '0;
        m_penable_o    = 1'b0;
        s_pready_o     = 1'b0;
        s_pslverr_o    = 1'b0;
        s_prdata_o     = '0;
        err_unmapped_o = 1'b0;
        err_timeout_o  = 1'b0;
        case (state)
            SETUP: begin
                m_psel_o[idx_q] = 1'b1;
            end
            ACCESS: begin
                m_psel_o[idx_q] = 1'b1;
                m_penable_o     = 1'b1;
            end
            RESP: begin
                s_pready_o    = 1'b1;
                s_pslverr_o   = slverr_q;
                s_prdata_o    = rdata_q;
                err_timeout_o = timeout_q;
            end
            ERR: begin
                s_pready_o     = 1'b1;
                s_pslverr_o    = 1'b1;
                err_unmapped_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign m_paddr_o  = addr_q;
    assign m_pwdata_o = wdata_q;
    assign m_pwrite_o = write_q;

endmodule

// File: tb/tb_apb_node_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_node_bridge
//
// Directed bench for apb_node_bridge with NB_SLV=12. A simple upstream APB
// master issues transfers; for each it pushes the expected upstream
// response (data, error, pulses, arrival cycle, downstream select length)
// and the expected downstream setup beat into queues. Independent monitors
// on the negative clock edge pop and compare whenever the DUT presents a
// downstream SETUP beat or an upstream PREADY.
// ---------------------------------------------------------------------------
module tb_apb_node_bridge;

    localparam int NB = 12;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [AW-1:0]     s_paddr_i;
    logic [DW-1:0]     s_pwdata_i;
    logic              s_pwrite_i;
    logic              s_psel_i;
    logic              s_penable_i;
    logic [DW-1:0]     s_prdata_o;
    logic              s_pready_o;
    logic              s_pslverr_o;
    logic [AW-1:0]     m_paddr_o;
    logic [DW-1:0]     m_pwdata_o;
    logic              m_pwrite_o;
    logic              m_penable_o;
    logic [NB-1:0]     m_psel_o;
    logic [NB*DW-1:0]  m_prdata_i;
    logic [NB-1:0]     m_pready_i;
    logic [NB-1:0]     m_pslverr_i;
    logic [NB*AW-1:0]  start_addr_i;
    logic [NB*AW-1:0]  end_addr_i;
    logic              err_unmapped_o;
    logic              err_timeout_o;

    apb_node_bridge #(
        .NB_SLV         (NB),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .s_paddr_i      (s_paddr_i),
        .s_pwdata_i     (s_pwdata_i),
        .s_pwrite_i     (s_pwrite_i),
        .s_psel_i       (s_psel_i),
        .s_penable_i    (s_penable_i),
        .s_prdata_o     (s_prdata_o),
        .s_pready_o     (s_pready_o),
        .s_pslverr_o    (s_pslverr_o),
        .m_paddr_o      (m_paddr_o),
        .m_pwdata_o     (m_pwdata_o),
        .m_pwrite_o     (m_pwrite_o),
        .m_penable_o    (m_penable_o),
        .m_psel_o       (m_psel_o),
        .m_prdata_i     (m_prdata_i),
        .m_pready_i     (m_pready_i),
        .m_pslverr_i    (m_pslverr_i),
        .start_addr_i   (start_addr_i),
        .end_addr_i     (end_addr_i),
        .err_unmapped_o (err_unmapped_o),
        .err_timeout_o  (err_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Peripheral models: per-port wait states, read data, error, and a
    // "junk" ready that is high even when the port is not selected.
    // -----------------------------------------------------------------------
    int          wait_cfg [NB];
    logic [31:0] rd_cfg   [NB];
    logic        err_cfg  [NB];
    logic        junk_rdy [NB];
    int          acc_cnt = 0;

    always @(posedge clk_i) acc_cnt <= m_penable_o ? acc_cnt + 1 : 0;

    always_comb begin
        m_pready_i  = '0;
        m_pslverr_i = '0;
        m_prdata_i  = '0;
        for (int i = 0; i < NB; i++) begin
            m_pready_i[i]          = junk_rdy[i] |
                                     (m_psel_o[i] & m_penable_o & (acc_cnt >= wait_cfg[i]));
            m_pslverr_i[i]         = err_cfg[i];
            m_prdata_i[i*DW +: DW] = rd_cfg[i];
        end
    end

    // -----------------------------------------------------------------------
    // Scoreboards
    // -----------------------------------------------------------------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        unm;
        logic        tmo;
        int          cyc;
        int          psel_n;
    } resp_t;

    typedef struct {
        logic [NB-1:0] sel;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic          wr;
    } ds_t;

    resp_t resp_q[$];
    ds_t   ds_q[$];
    int    psel_cycles = 0;

    always @(negedge clk_i) begin
        resp_t r;
        ds_t   d;
        if (rst_i) begin
            psel_cycles = 0;
        end else begin
            if (m_psel_o != '0) psel_cycles++;

            if ((m_psel_o != '0) && !m_penable_o) begin
                if (ds_q.size() == 0) begin
                    check("ds_unexpected_setup", {52'd0, m_psel_o}, 64'd0);
                end else begin
                    d = ds_q.pop_front();
                    check("ds_psel",  {52'd0, m_psel_o}, {52'd0, d.sel});
                    check("ds_paddr", {32'd0, m_paddr_o}, {32'd0, d.addr});
                    check("ds_pwrite", {63'd0, m_pwrite_o}, {63'd0, d.wr});
                    if (d.wr) check("ds_pwdata", {32'd0, m_pwdata_o}, {32'd0, d.wdata});
                end
            end

            if (s_pready_o) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected_pready", 64'd1, 64'd0);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_prdata",   {32'd0, s_prdata_o},  {32'd0, r.rdata});
                    check("resp_pslverr",  {63'd0, s_pslverr_o}, {63'd0, r.err});
                    check("resp_unmapped", {63'd0, err_unmapped_o}, {63'd0, r.unm});
                    check("resp_timeout",  {63'd0, err_timeout_o},  {63'd0, r.tmo});
                    check("resp_cycle",    64'(cyc), 64'(r.cyc));
                    check("resp_psel_len", 64'(psel_cycles), 64'(r.psel_n));
                end
                psel_cycles = 0;
            end else begin
                check("quiet_outside_resp",
                      {29'd0, s_pslverr_o, err_unmapped_o, err_timeout_o, s_prdata_o}, 64'd0);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Upstream master
    // -----------------------------------------------------------------------
    task automatic set_map(input int i, input logic [31:0] s, input logic [31:0] e);
        start_addr_i[i*AW +: AW] = s;
        end_addr_i[i*AW +: AW]   = e;
    endtask

    // acc = number of downstream ACCESS cycles (ignored when sel == 0).
    task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                           input logic [NB-1:0] sel, input logic [31:0] rdata,
                           input logic err, input logic unm, input logic tmo, input int acc);
        resp_t r;
        ds_t   d;
        bit    done = 0;
        @(posedge clk_i); #1;
        s_paddr_i   = addr;
        s_pwdata_i  = wdata;
        s_pwrite_i  = wr;
        s_psel_i    = 1'b1;
        s_penable_i = 1'b0;
        r.rdata  = rdata;
        r.err    = err;
        r.unm    = unm;
        r.tmo    = tmo;
        r.cyc    = (sel == '0) ? cyc + 1 : cyc + 2 + acc;
        r.psel_n = (sel == '0) ? 0 : 1 + acc;
        resp_q.push_back(r);
        if (sel != '0) begin
            d.sel   = sel;
            d.addr  = addr;
            d.wdata = wdata;
            d.wr    = wr;
            ds_q.push_back(d);
        end
        @(posedge clk_i); #1;
        s_penable_i = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (s_pready_o) begin
                done = 1;
                break;
            end
        end
        if (!done) check("xfer_no_pready", 64'd0, 64'd1);
        @(posedge clk_i); #1;
        s_psel_i    = 1'b0;
        s_penable_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ds_t d;
        bit  seen;

        rst_i       = 1'b1;
        s_paddr_i   = '0;
        s_pwdata_i  = '0;
        s_pwrite_i  = 1'b0;
        s_psel_i    = 1'b0;
        s_penable_i = 1'b0;
        start_addr_i = '0;
        end_addr_i   = '0;

        for (int i = 0; i < NB; i++) begin
            wait_cfg[i] = 0;
            rd_cfg[i]   = 32'hF000_0000 | 32'(i);
            err_cfg[i]  = 1'b0;
            junk_rdy[i] = 1'b0;
            set_map(i, 32'h3000_0000 + 32'(i) * 32'h1000, 32'h3000_0FFF + 32'(i) * 32'h1000);
        end
        set_map(0, 32'h1A10_0000, 32'h1A10_0FFF);
        set_map(1, 32'h1A10_1000, 32'h1A10_1FFF);
        set_map(2, 32'h1A10_2000, 32'h1A10_2FFF);
        set_map(3, 32'h1A10_5000, 32'h1A10_5FFF);
        set_map(4, 32'h1A10_3000, 32'h1A10_3FFF);
        set_map(5, 32'h1A10_4000, 32'h1A10_5FFF);
        set_map(6, 32'h1A10_6000, 32'h1A10_6FFF);
        rd_cfg[0]   = 32'hA0A0_A0A0;
        rd_cfg[1]   = 32'h1111_1111;
        rd_cfg[2]   = 32'h1234_5678;
        rd_cfg[3]   = 32'hCAFE_0003;
        rd_cfg[4]   = 32'h4444_4444;
        wait_cfg[1] = 1;
        wait_cfg[2] = 3;
        wait_cfg[4] = 2;
        wait_cfg[6] = 1000;
        err_cfg[4]  = 1'b1;
        err_cfg[5]  = 1'b1;
        junk_rdy[5] = 1'b1;

        #12;
        check("rst_psel",     {52'd0, m_psel_o}, 64'd0);
        check("rst_penable",  {63'd0, m_penable_o}, 64'd0);
        check("rst_pready",   {63'd0, s_pready_o}, 64'd0);
        check("rst_upstream", {31'd0, s_pslverr_o, s_prdata_o}, 64'd0);
        check("rst_pulses",   {62'd0, err_unmapped_o, err_timeout_o}, 64'd0);
        check("rst_paddr",    {32'd0, m_paddr_o}, 64'd0);
        check("rst_pwdata",   {31'd0, m_pwrite_o, m_pwdata_o}, 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // addr, wdata, wr, sel, rdata, err, unm, tmo, access cycles
        do_xfer(32'h1A10_0004, 32'hDEAD_BEEF, 1'b1, 12'h001, 32'h0,         1'b0, 1'b0, 1'b0, 1);
        do_xfer(32'h1A10_2010, 32'h0,         1'b0, 12'h004, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 4);
        do_xfer(32'h1A1F_0000, 32'h0,         1'b0, 12'h000, 32'h0,         1'b1, 1'b1, 1'b0, 0);
        do_xfer(32'h1A10_5000, 32'h0,         1'b0, 12'h008, 32'hCAFE_0003, 1'b0, 1'b0, 1'b0, 1);
        do_xfer(32'h1A10_0FFF, 32'h0,         1'b0, 12'h001, 32'hA0A0_A0A0, 1'b0, 1'b0, 1'b0, 1);
        do_xfer(32'h1A10_1000, 32'h0,         1'b0, 12'h002, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 2);
        do_xfer(32'h1A10_3008, 32'h0,         1'b0, 12'h010, 32'h4444_4444, 1'b1, 1'b0, 1'b0, 3);
        do_xfer(32'h1A10_2000, 32'h0BAD_F00D, 1'b1, 12'h004, 32'h0,         1'b0, 1'b0, 1'b0, 4);
        do_xfer(32'h0000_0000, 32'h5A5A_5A5A, 1'b1, 12'h000, 32'h0,         1'b1, 1'b1, 1'b0, 0);
`ifdef APB_NODE_TIMEOUT_EN
        do_xfer(32'h1A10_6000, 32'h0,         1'b0, 12'h040, 32'h0,         1'b1, 1'b0, 1'b1, 8);
`endif

        // Reset in the middle of a downstream ACCESS phase.
        @(posedge clk_i); #1;
        s_paddr_i   = 32'h1A10_2020;
        s_pwrite_i  = 1'b0;
        s_psel_i    = 1'b1;
        s_penable_i = 1'b0;
        d.sel   = 12'h004;
        d.addr  = 32'h1A10_2020;
        d.wdata = 32'h0;
        d.wr    = 1'b0;
        ds_q.push_back(d);
        @(posedge clk_i); #1;
        s_penable_i = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (m_penable_o) begin
                seen = 1;
                break;
            end
        end
        check("reset_reached_access", {63'd0, seen}, 64'd1);
        #1 rst_i = 1'b1;
        #1;
        check("reset_psel_now",    {52'd0, m_psel_o}, 64'd0);
        check("reset_penable_now", {63'd0, m_penable_o}, 64'd0);
        check("reset_pready_now",  {63'd0, s_pready_o}, 64'd0);
        s_psel_i    = 1'b0;
        s_penable_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        do_xfer(32'h1A10_1004, 32'h5555_AAAA, 1'b1, 12'h002, 32'h0,         1'b0, 1'b0, 1'b0, 2);

        repeat (5) @(posedge clk_i);
        #1;
        check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        check("ds_queue_drained",   64'(ds_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
